rmio_eu_endpoint: RTL and testbench

//   EU-side terminator of the RMIO link: the responder at the far end of the registered RF->EU stage.

---
 rtl/rmio_eu_endpoint.sv | 125 ++++++++++++
 tb/tb_rmio_eu_endpoint.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rmio_eu_endpoint.sv
// EU-side terminator of the RMIO link: input FIFO (RF writes -> EU valid/ready) and output FIFO
// (EU results -> RF read strobes, registered). Optional error flags under `RMIO_EP_ERR_EN`.
module rmio_eu_endpoint #(
  parameter int DATA_W    = 32,
  parameter int IN_DEPTH  = 8,
  parameter int OUT_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            rmio_input_data,
  input  logic                         rmio_input_we,
  input  logic                         rmio_output_re,
  output logic [DATA_W-1:0]            rmio_output_data,
  output logic [DATA_W-1:0]            eu_in_data,
  output logic                         eu_in_valid,
  input  logic                         eu_in_ready,
  input  logic [DATA_W-1:0]            eu_out_data,
  input  logic                         eu_out_valid,
  output logic                         eu_out_ready,
`ifdef RMIO_EP_ERR_EN
  input  logic                         err_clr,
  output logic                         in_ovf,
  output logic                         out_udf,
`endif
  output logic [$clog2(IN_DEPTH):0]    in_count,
  output logic [$clog2(OUT_DEPTH):0]   out_count
);

  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int IN_CW  = IN_AW + 1;
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam int OUT_CW = OUT_AW + 1;

  logic [DATA_W-1:0] in_mem_r  [IN_DEPTH];
  logic [DATA_W-1:0] out_mem_r [OUT_DEPTH];
  logic [IN_AW-1:0]  in_wr_ptr_r, in_rd_ptr_r;
  logic [OUT_AW-1:0] out_wr_ptr_r, out_rd_ptr_r;
  logic [IN_CW-1:0]  in_count_r;
  logic [OUT_CW-1:0] out_count_r;
  logic [DATA_W-1:0] rd_data_r;

  logic in_full_s, in_valid_s, in_pop_s, in_push_s;
  logic out_ready_s, out_nonempty_s, out_push_s, out_pop_s;

  // Input FIFO: full is judged on the registered count, but a same-cycle EU pop frees the slot.
  assign in_full_s  = (in_count_r == IN_CW'(IN_DEPTH));
  assign in_valid_s = (in_count_r != {IN_CW{1'b0}});
  assign in_pop_s   = in_valid_s & eu_in_ready;
  assign in_push_s  = rmio_input_we & (~in_full_s | in_pop_s);

  // Output FIFO: ready depends only on registered count, no pop credit.
  assign out_ready_s    = (out_count_r != OUT_CW'(OUT_DEPTH));
  assign out_nonempty_s = (out_count_r != {OUT_CW{1'b0}});
  assign out_push_s     = eu_out_valid & out_ready_s;
  assign out_pop_s      = rmio_output_re & out_nonempty_s;

  assign eu_in_data   = in_mem_r[in_rd_ptr_r];
  assign eu_in_valid  = in_valid_s;
  assign eu_out_ready = out_ready_s;
  assign in_count     = in_count_r;
  assign out_count    = out_count_r;
  assign rmio_output_data = rd_data_r;

  // Storage arrays carry no reset; their contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (in_push_s) begin
      in_mem_r[in_wr_ptr_r] <= rmio_input_data;
    end
    if (out_push_s) begin
      out_mem_r[out_wr_ptr_r] <= eu_out_data;
    end
  end

  // Input FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_wr_ptr_r <= {IN_AW{1'b0}};
      in_rd_ptr_r <= {IN_AW{1'b0}};
      in_count_r  <= {IN_CW{1'b0}};
    end else begin
      if (in_push_s) in_wr_ptr_r <= in_wr_ptr_r + IN_AW'(1);
      if (in_pop_s)  in_rd_ptr_r <= in_rd_ptr_r + IN_AW'(1);
      in_count_r <= in_count_r + IN_CW'(in_push_s) - IN_CW'(in_pop_s);
    end
  end

  // Output FIFO pointers, occupancy and registered read return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_wr_ptr_r <= {OUT_AW{1'b0}};
      out_rd_ptr_r <= {OUT_AW{1'b0}};
      out_count_r  <= {OUT_CW{1'b0}};
      rd_data_r    <= {DATA_W{1'b0}};
    end else begin
      if (out_push_s) out_wr_ptr_r <= out_wr_ptr_r + OUT_AW'(1);
      if (out_pop_s) begin
        out_rd_ptr_r <= out_rd_ptr_r + OUT_AW'(1);
        rd_data_r    <= out_mem_r[out_rd_ptr_r];
      end
      out_count_r <= out_count_r + OUT_CW'(out_push_s) - OUT_CW'(out_pop_s);
    end
  end

`ifdef RMIO_EP_ERR_EN
  logic in_drop_s, out_udf_s, in_ovf_r, out_udf_r;
  assign in_drop_s = rmio_input_we & ~in_push_s;
  assign out_udf_s = rmio_output_re & ~out_nonempty_s;
  assign in_ovf    = in_ovf_r;
  assign out_udf   = out_udf_r;

  // Sticky error flags; a set event outranks a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ovf_r  <= 1'b0;
      out_udf_r <= 1'b0;
    end else begin
      if (in_drop_s)    in_ovf_r <= 1'b1;
      else if (err_clr) in_ovf_r <= 1'b0;
      if (out_udf_s)    out_udf_r <= 1'b1;
      else if (err_clr) out_udf_r <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_rmio_eu_endpoint.sv
// Self-checking bench for rmio_eu_endpoint: directed scenarios plus a randomized run against a
// queue-based scoreboard. Error-flag checks are compiled in when RMIO_EP_ERR_EN is defined.
module tb_rmio_eu_endpoint;
  localparam int DW  = 32;
  localparam int IND = 8;
  localparam int OUD = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [DW-1:0] rmio_input_data = '0;
  logic rmio_input_we = 1'b0;
  logic rmio_output_re = 1'b0;
  logic [DW-1:0] rmio_output_data;
  logic [DW-1:0] eu_in_data;
  logic eu_in_valid;
  logic eu_in_ready = 1'b0;
  logic [DW-1:0] eu_out_data = '0;
  logic eu_out_valid = 1'b0;
  logic eu_out_ready;
  logic [$clog2(IND):0] in_count;
  logic [$clog2(OUD):0] out_count;
`ifdef RMIO_EP_ERR_EN
  logic err_clr = 1'b0;
  logic in_ovf, out_udf;
  logic m_ovf = 1'b0;
  logic m_udf = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_drop = 0;
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] out_q[$];
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] last_rd = '0;

  always #5 clk = ~clk;

  rmio_eu_endpoint #(.DATA_W(DW), .IN_DEPTH(IND), .OUT_DEPTH(OUD)) dut (
    .clk(clk), .rst(rst),
    .rmio_input_data(rmio_input_data), .rmio_input_we(rmio_input_we),
    .rmio_output_re(rmio_output_re), .rmio_output_data(rmio_output_data),
    .eu_in_data(eu_in_data), .eu_in_valid(eu_in_valid), .eu_in_ready(eu_in_ready),
    .eu_out_data(eu_out_data), .eu_out_valid(eu_out_valid), .eu_out_ready(eu_out_ready),
`ifdef RMIO_EP_ERR_EN
    .err_clr(err_clr), .in_ovf(in_ovf), .out_udf(out_udf),
`endif
    .in_count(in_count), .out_count(out_count)
  );

  // Drive one cycle of stimulus at a negedge, update the scoreboard at the posedge, return at negedge.
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic rdy,
                      input logic ov, input logic [DW-1:0] od, input logic re, input logic clr);
    logic p_in, q_in, p_out, q_out;
    rmio_input_we = we; rmio_input_data = wd; eu_in_ready = rdy;
    eu_out_valid = ov; eu_out_data = od; rmio_output_re = re;
`ifdef RMIO_EP_ERR_EN
    err_clr = clr;
`endif
    q_in  = (in_q.size() != 0) && rdy;
    p_in  = we && ((in_q.size() < IND) || q_in);
    p_out = ov && (out_q.size() < OUD);
    q_out = re && (out_q.size() != 0);
    @(posedge clk);
    if (q_in) in_q.delete(0);
    if (p_in) in_q.push_back(wd);
    if (we && !p_in) n_drop++;
    if (q_out) begin
      last_rd = out_q.pop_front();
      rd_q.push_back(last_rd);
    end
    if (p_out) out_q.push_back(od);
`ifdef RMIO_EP_ERR_EN
    if (we && !p_in) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (re && !q_out) m_udf = 1'b1; else if (clr) m_udf = 1'b0;
`else
    if (clr) n_drop = n_drop + 0;
`endif
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset_midcycle();
    #2 rst = 1'b1;
    in_q.delete(); out_q.delete(); rd_q.delete(); last_rd = '0;
`ifdef RMIO_EP_ERR_EN
    m_ovf = 1'b0; m_udf = 1'b0;
`endif
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    apply_reset_midcycle();
    n_cmp++; if (rmio_output_data !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", rmio_output_data); end
    n_cmp++; if (in_count !== 4'd0 || out_count !== 4'd0) begin n_err++; $display("FAIL reset_counts got %0d/%0d want 0/0", in_count, out_count); end
    n_cmp++; if (eu_in_valid !== 1'b0 || eu_out_ready !== 1'b1) begin n_err++; $display("FAIL reset_hs valid=%b ready=%b want 0/1", eu_in_valid, eu_out_ready); end
`ifdef RMIO_EP_ERR_EN
    n_cmp++; if (in_ovf !== 1'b0 || out_udf !== 1'b0) begin n_err++; $display("FAIL reset_err got %b%b want 00", in_ovf, out_udf); end
`endif
    @(negedge clk); rst = 1'b0;
    idle();
  endtask

  task automatic test_input_basic();
    step(1'b1, 32'h11, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (eu_in_valid !== 1'b1 || eu_in_data !== 32'h11) begin n_err++; $display("FAIL in_visible got %b/%h want 1/11", eu_in_valid, eu_in_data); end
    step(1'b1, 32'h22, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 32'h33, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (in_count !== 4'd3 || eu_in_data !== 32'h11) begin n_err++; $display("FAIL in_three got %0d/%h want 3/11", in_count, eu_in_data); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (eu_in_valid !== 1'b1 || eu_in_data !== in_q[0]) begin n_err++; $display("FAIL in_consume%0d got %b/%h want 1/%h", i, eu_in_valid, eu_in_data, in_q[0]); end
      step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    end
    n_cmp++; if (eu_in_valid !== 1'b0 || in_count !== 4'd0) begin n_err++; $display("FAIL in_drained got %b/%0d want 0/0", eu_in_valid, in_count); end
  endtask

  task automatic test_input_full();
    for (int i = 0; i < IND; i++) step(1'b1, 32'h100 + i, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (in_count !== 4'd8) begin n_err++; $display("FAIL in_full_cnt got %0d want 8", in_count); end
    step(1'b1, 32'hDEAD, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (in_count !== 4'd8 || eu_in_data !== 32'h100) begin n_err++; $display("FAIL in_drop got %0d/%h want 8/100", in_count, eu_in_data); end
`ifdef RMIO_EP_ERR_EN
    n_cmp++; if (in_ovf !== m_ovf || in_ovf !== 1'b1) begin n_err++; $display("FAIL in_ovf got %b want 1", in_ovf); end
`endif
    step(1'b1, 32'hDEAD, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (in_count !== 4'd8 || eu_in_data !== 32'h101) begin n_err++; $display("FAIL in_popcredit got %0d/%h want 8/101", in_count, eu_in_data); end
    for (int i = 0; i < IND; i++) begin
      n_cmp++; if (eu_in_data !== in_q[0]) begin n_err++; $display("FAIL in_drain%0d got %h want %h", i, eu_in_data, in_q[0]); end
      if (i == IND - 1) begin
        n_cmp++; if (eu_in_data !== 32'hDEAD) begin n_err++; $display("FAIL in_tail got %h want dead", eu_in_data); end
      end
      step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    end
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
`ifdef RMIO_EP_ERR_EN
    n_cmp++; if (in_ovf !== 1'b0) begin n_err++; $display("FAIL in_ovf_clr got %b want 0", in_ovf); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp;
    for (int i = 0; i < OUD; i++) step(1'b0, '0, 1'b0, 1'b1, 32'hA0 + i, 1'b0, 1'b0);
    n_cmp++; if (eu_out_ready !== 1'b0 || out_count !== 4'd8) begin n_err++; $display("FAIL out_full got %b/%0d want 0/8", eu_out_ready, out_count); end
    step(1'b0, '0, 1'b0, 1'b1, 32'hA8, 1'b0, 1'b0);
    for (int i = 0; i < OUD; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      exp = rd_q.pop_front();
      n_cmp++; if (rmio_output_data !== exp || exp !== 32'hA0 + i) begin n_err++; $display("FAIL b2b_rd%0d got %h want %h", i, rmio_output_data, exp); end
    end
    n_cmp++; if (out_count !== 4'd0 || eu_out_ready !== 1'b1) begin n_err++; $display("FAIL out_empty got %0d/%b want 0/1", out_count, eu_out_ready); end
  endtask

  task automatic test_read_empty();
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (rmio_output_data !== 32'hA7) begin n_err++; $display("FAIL udf_hold got %h want a7", rmio_output_data); end
`ifdef RMIO_EP_ERR_EN
    n_cmp++; if (out_udf !== 1'b1) begin n_err++; $display("FAIL out_udf got %b want 1", out_udf); end
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    n_cmp++; if (out_udf !== m_udf || out_udf !== 1'b1) begin n_err++; $display("FAIL udf_set_wins got %b want 1", out_udf); end
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    n_cmp++; if (out_udf !== 1'b0) begin n_err++; $display("FAIL udf_clr got %b want 0", out_udf); end
`endif
    step(1'b0, '0, 1'b0, 1'b1, 32'hB5, 1'b1, 1'b0);
    n_cmp++; if (rmio_output_data !== 32'hA7 || out_count !== 4'd1) begin n_err++; $display("FAIL no_bypass got %h/%0d want a7/1", rmio_output_data, out_count); end
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (rmio_output_data !== rd_q.pop_front()) begin n_err++; $display("FAIL late_rd got %h want b5", rmio_output_data); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 32'h55, 1'b0, 1'b1, 32'h66, 1'b0, 1'b0);
    step(1'b1, 32'h57, 1'b0, 1'b1, 32'h67, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    rd_q.delete();
    apply_reset_midcycle();
    n_cmp++; if (in_count !== 4'd0 || out_count !== 4'd0 || eu_in_valid !== 1'b0) begin n_err++; $display("FAIL midrst got %0d/%0d/%b want 0/0/0", in_count, out_count, eu_in_valid); end
    n_cmp++; if (rmio_output_data !== 32'h0) begin n_err++; $display("FAIL midrst_rdata got %h want 0", rmio_output_data); end
    @(negedge clk); rst = 1'b0;
    idle();
  endtask

  task automatic test_random();
    int errs_before;
    errs_before = n_err;
    for (int c = 0; c < 10000; c++) begin
      if (n_err - errs_before < 10) begin
        n_cmp++; if (in_count !== ($clog2(IND)+1)'(in_q.size()) || eu_in_valid !== (in_q.size() != 0)) begin n_err++; $display("FAIL rnd_in c%0d got %0d/%b want %0d", c, in_count, eu_in_valid, in_q.size()); end
        if (in_q.size() != 0) begin
          n_cmp++; if (eu_in_data !== in_q[0]) begin n_err++; $display("FAIL rnd_head c%0d got %h want %h", c, eu_in_data, in_q[0]); end
        end
        n_cmp++; if (out_count !== ($clog2(OUD)+1)'(out_q.size()) || eu_out_ready !== (out_q.size() != OUD)) begin n_err++; $display("FAIL rnd_out c%0d got %0d/%b want %0d", c, out_count, eu_out_ready, out_q.size()); end
        n_cmp++; if (rmio_output_data !== last_rd) begin n_err++; $display("FAIL rnd_rd c%0d got %h want %h", c, rmio_output_data, last_rd); end
`ifdef RMIO_EP_ERR_EN
        n_cmp++; if (in_ovf !== m_ovf || out_udf !== m_udf) begin n_err++; $display("FAIL rnd_err c%0d got %b%b want %b%b", c, in_ovf, out_udf, m_ovf, m_udf); end
`endif
      end
      rd_q.delete();
      step(($urandom_range(99) < 55), $urandom, ($urandom_range(99) < 40),
           ($urandom_range(99) < 50), $urandom, ($urandom_range(99) < 40),
           ($urandom_range(99) < 5));
    end
  endtask

  initial begin
    test_reset();
    test_input_basic();
    test_input_full();
    test_back_to_back();
    test_read_empty();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
